// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter for the shared register-file write port
// Optional RF_ARB_FIXED_PRIO_EN: requester 0 wins outright, 1..NUM_REQ-1 rotate among themselves.
module rf_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wr_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [(1<<ADDR_W)-1:0]    wr_sel,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy
);

  localparam int SEL_W = 1 << ADDR_W;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef RF_ARB_FIXED_PRIO_EN
  localparam int RR_LO = 1;
`else
  localparam int RR_LO = 0;
`endif
  localparam int RR_N = NUM_REQ - RR_LO;
  localparam logic [ADDR_W-1:0] XZR = {ADDR_W{1'b1}};

  logic [PTR_W-1:0]  rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic              found;
  int                idx;
  logic              hs;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              wr_en_q;
  logic [SEL_W-1:0]  wr_sel_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // Scan the rotating window starting at rr_ptr; first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
`ifdef RF_ARB_FIXED_PRIO_EN
    if (req_valid[0]) begin
      gnt[0] = 1'b1;
      found  = 1'b1;
    end
`endif
    for (int k = 0; k < RR_N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - RR_N;
      if (!found && req_valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
        found    = 1'b1;
      end
    end
  end

  assign req_ready = (reset || wr_stall) ? '0 : gnt;
  assign hs        = |req_ready;
  assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= PTR_W'(RR_LO);
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q  <= 1'b0;
      wr_sel_q <= '0;
      if (hs) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
        // XZR completes the handshake but never touches the array.
        wr_en_q   <= (sel_addr != XZR);
        wr_sel_q  <= (sel_addr != XZR) ? (SEL_W'(1) << sel_addr) : '0;
        if (!(RR_LO == 1 && gnt_idx == '0)) begin
          rr_ptr <= (int'(gnt_idx) == NUM_REQ-1) ? PTR_W'(RR_LO) : gnt_idx + PTR_W'(1);
        end
      end
    end
  end

  // Reset drops a write already sitting in the output stage.
  assign wr_en   = wr_en_q & ~reset;
  assign wr_sel  = wr_sel_q & {SEL_W{~reset}};
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = |(req_valid & ~req_ready);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter
module tb_rf_write_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   req_valid;
  logic [14:0]  req_addr;
  logic [191:0] req_data;
  logic [2:0]   req_ready;
  logic         wr_stall;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_sel;
  logic [63:0]  wr_data;
  logic         busy;

  logic [4:0]  a0, a1, a2;
  logic [63:0] d0, d1, d2;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] sel;
    logic [63:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  rf_write_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wr_stall(wr_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  assign req_addr = {a2, a1, a0};
  assign req_data = {d2, d1, d0};

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every write the array sees must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {59'd0, wr_addr}, 64'hFFFF);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", {59'd0, wr_addr}, {59'd0, e.addr});
          chk("wr_sel", {32'd0, wr_sel}, {32'd0, e.sel});
          chk("wr_data", wr_data, e.data);
        end
      end else begin
        chk("wr_sel_idle", {32'd0, wr_sel}, 64'd0);
      end
    end
  end

  // One cycle: drive at posedge+1, check grant/busy at negedge, push the expected write.
  // en_chk: 0/1 checks the registered wr_en this cycle, 2 skips.
  task automatic step(input logic [2:0] v, input logic st, input logic [2:0] er,
                      input logic eb, input int en_chk);
    wr_t e;
    req_valid = v;
    wr_stall  = st;
    @(negedge clk);
    chk("req_ready", {61'd0, req_ready}, {61'd0, er});
    chk("busy", {63'd0, busy}, {63'd0, eb});
    if (en_chk != 2) begin
      chk("wr_en", {63'd0, wr_en}, 64'(en_chk));
      if (en_chk == 0) chk("wr_sel_off", {32'd0, wr_sel}, 64'd0);
    end
    if (!reset && er != 3'b000) begin
      case (er)
        3'b001:  begin e.addr = a0; e.data = d0; end
        3'b010:  begin e.addr = a1; e.data = d1; end
        default: begin e.addr = a2; e.data = d2; end
      endcase
      e.sel = 32'd1 << e.addr;
      if (e.addr != 5'd31) sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; wr_stall = 1'b0;
    a0 = '0; a1 = '0; a2 = '0; d0 = '0; d1 = '0; d2 = '0;
    @(posedge clk);
    #1;
    // Reset held two cycles: no grants even with requests present.
    step(3'b111, 1'b0, 3'b000, 1'b1, 0);
    step(3'b111, 1'b0, 3'b000, 1'b1, 0);
    chk("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_wr_sel", {32'd0, wr_sel}, 64'd0);
    reset = 1'b0;

`ifdef RF_ARB_FIXED_PRIO_EN
    a0 = 5'd4; a1 = 5'd6; a2 = 5'd7;
    d0 = 64'hA0; d1 = 64'hA1; d2 = 64'hA2;
    for (int i = 0; i < 4; i++) step(3'b111, 1'b0, 3'b001, 1'b1, 2);
    step(3'b110, 1'b0, 3'b010, 1'b1, 1);
    step(3'b110, 1'b0, 3'b100, 1'b1, 1);
    step(3'b110, 1'b0, 3'b010, 1'b1, 1);
    step(3'b110, 1'b0, 3'b100, 1'b1, 1);
    step(3'b000, 1'b0, 3'b000, 1'b0, 1);
`else
    // Single request; expected write is addr 5, sel 0x20.
    a0 = 5'd5; d0 = 64'hDEAD_BEEF_0000_0001;
    step(3'b001, 1'b0, 3'b001, 1'b0, 0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 1);
    chk("single_sel", {32'd0, sb.size() == 0 ? 32'h20 : 32'h0}, 64'h20);
    // rr_ptr is 1; a lone requester 2 grant brings it back to 0.
    a2 = 5'd3; d2 = 64'h2222;
    step(3'b100, 1'b0, 3'b100, 1'b0, 0);
    // Fairness: 0,1,2,0,1,2 with sel 0x2,0x4,0x8.
    a0 = 5'd1; a1 = 5'd2; d0 = 64'h1111_0000; d1 = 64'h1111;
    step(3'b111, 1'b0, 3'b001, 1'b1, 1);
    step(3'b111, 1'b0, 3'b010, 1'b1, 1);
    step(3'b111, 1'b0, 3'b100, 1'b1, 1);
    step(3'b111, 1'b0, 3'b001, 1'b1, 1);
    step(3'b111, 1'b0, 3'b010, 1'b1, 1);
    step(3'b111, 1'b0, 3'b100, 1'b1, 1);
    // XZR: handshake, no write, pointer moves past requester 1.
    a1 = 5'd31; d1 = 64'hFFFF;
    step(3'b010, 1'b0, 3'b010, 1'b0, 1);
    a1 = 5'd2; d1 = 64'h1112;
    step(3'b111, 1'b0, 3'b100, 1'b1, 0);
    // Stall blocks grants; requester 0 wins once it lifts.
    step(3'b011, 1'b1, 3'b000, 1'b1, 1);
    step(3'b011, 1'b1, 3'b000, 1'b1, 0);
    step(3'b011, 1'b1, 3'b000, 1'b1, 0);
    step(3'b011, 1'b0, 3'b001, 1'b1, 0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 1);
    // Mid-operation reset drops the registered write.
    step(3'b010, 1'b0, 3'b010, 1'b0, 0);
    void'(sb.pop_back());
    reset = 1'b1;
    step(3'b000, 1'b0, 3'b000, 1'b0, 0);
    reset = 1'b0;
    step(3'b111, 1'b0, 3'b001, 1'b1, 0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 1);
`endif
    step(3'b000, 1'b0, 3'b000, 1'b0, 0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
